apb_pwm_multi: RTL and testbench
================================

// Module: apb_pwm_multi
// PURPOSE
//  APB3 slave driving NUM_CH independent PWM outputs from one shared period counter; successor to the single-channel audio PWM wrapper.
//  Adds per-channel duty, programmable period, double-buffered (glitch-free) updates, read-back and full APB error reporting.
//  Sits on the peripheral APB bus next to the other pclk_i-domain slaves; pwm_o drives pads or audio filters directly.
// PARAMETERS
//  NUM_CH  4   number of PWM channels, 1..8
//  CNT_W   16  counter/period/duty width, 2..32
// PORTS
//  pclk_i     in   1          sole clock; all logic on its rising edge
//  preset_i   in   1          reset, synchronous, active-high
//  paddr_i    in   32         byte address; bits [11:0] decoded
//  psel_i     in   1          APB select
//  penable_i  in   1          APB access phase
//  pwrite_i   in   1          1=write, 0=read
//  pwdata_i   in   32         write data
//  pstrb_i    in   4          byte strobes; a byte is written only when its strobe is 1
//  pready_o   out  1          transfer complete
//  prdata_o   out  32         read data, 0 unless a valid read access phase
//  pslverr_o  out  1          transfer error, valid with pready_o
//  pwm_o      out  NUM_CH     PWM outputs
//  irq_o      out  1          wrap interrupt (PWM_IRQ_EN only, else tied 0)
// BEHAVIOUR
//  Reset (preset_i=1 at a pclk_i edge): all registers 0, pwm_o=0, irq_o=0, counter=0; PERIOD resets to all ones.
//  APB: setup = psel&~penable; access = psel&penable. pready_o=1 in every access phase (no wait states), 0 otherwise.
//  Write commits at the access-phase edge only if pslverr_o=0; no register changes on an errored transfer.
//  pslverr_o=1 in access phase for: paddr[1:0]!=0; unmapped address; write to STATUS. Else 0.
//  Register map (fields wider than CNT_W are zero; reads of unused bits return 0):
//   0x00 CTRL   RW  [0] EN, [1] CLR (write-1 pulse, reads 0), [2] INV (invert all pwm_o)
//   0x04 PERIOD RW  [CNT_W-1:0] last counter value of a period; period length = PERIOD+1 cycles
//   0x08 STATUS RO  [CNT_W-1:0] current counter
//   0x0C IRQ    RW  [0] PEND (W1C), [1] IE    -- unmapped without PWM_IRQ_EN
//   0x10+4*i DUTY[i] RW [CNT_W-1:0], i<NUM_CH; higher offsets unmapped
//  Counter: EN=0 -> cnt held 0, shadow PERIOD/DUTY track programmed values every cycle.
//   EN=1 -> cnt++ each cycle; when cnt==period_sh, cnt<=0 and shadows reload (wrap).
//   CLR write -> cnt<=0 and shadows reload next edge, overriding wrap/increment that cycle.
//  Output: pwm_o[i] registered = EN & (cnt < duty_sh[i]), XOR INV; one cycle latency from cnt.
//   DUTY=0 -> constant low; DUTY>PERIOD -> constant high; PERIOD=0 -> period of 1 cycle.
//  PERIOD/DUTY writes while EN=1 take effect only at next wrap or CLR; never mid-period.
//  Write coinciding with wrap: shadow loads the newly written value in the same edge.
//  EN 1->0: cnt=0, pwm_o goes 0 (or 1 if INV) next edge. Reset mid-operation aborts period immediately.
// CONFIGURATION
//  PWM_IRQ_EN defined: wrap event sets PEND; irq_o = PEND & IE, registered. Wrap and W1C in same cycle -> PEND stays 1.
//  PWM_IRQ_EN undefined: no IRQ register (0x0C errors), irq_o constant 0, no wrap-flag logic.
// TESTING
//  Reset, then read 0x00/0x04/0x08 -> 0, 0x0000FFFF (CNT_W=16), 0; pwm_o=0, pslverr_o=0.
//  PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, EN=1 -> pwm_o[0] high 3 of every 10 cycles, [1] always 0, [2] always 1.
//  EN=1, PERIOD=9, DUTY0=3; at cnt=4 write DUTY0=7 -> remainder of period unchanged; next period high 7 cycles.
//  Read 0x02, read 0x40 (NUM_CH=4), write 0x08 -> pslverr_o=1, pready_o=1, registers unchanged.
//  Write CTRL=0x3 at cnt=5 -> STATUS reads 0 next cycle; INV=1 with DUTY0=3 -> pwm_o[0] low 3 of 10.
//  PWM_IRQ_EN: IE=1, PERIOD=4 -> irq_o rises 1 cycle after wrap; W1C PEND -> irq_o 0 until next wrap.

Source files
------------

// File: rtl/apb_pwm_multi_if.sv
// APB3 bus bundle for apb_pwm_multi; signal names follow the slave's point of view.
interface apb_pwm_multi_if;
  logic [31:0] paddr_i;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;

  modport master (
    output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_pwm_multi.sv
// APB3 slave with NUM_CH PWM channels sharing one period counter, double-buffered period/duty.
// Optional wrap interrupt (IRQ register at 0x0C, irq_o) is built only when PWM_IRQ_EN is defined.
module apb_pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  apb_pwm_multi_if.slave    apb,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_PERIOD, SEL_STATUS, SEL_IRQ, SEL_DUTY, SEL_NONE
  } reg_sel_e;

  typedef logic [CNT_W-1:0] cnt_t;

  logic              en_q, en_d, inv_q, inv_d;
  cnt_t              period_q, period_d, period_sh_q, period_sh_d;
  cnt_t              cnt_q, cnt_d;
  cnt_t              duty_q [NUM_CH];
  cnt_t              duty_d [NUM_CH];
  cnt_t              duty_sh_q [NUM_CH];
  cnt_t              duty_sh_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;

  reg_sel_e          sel;
  logic [IDX_W-1:0]  duty_idx;
  logic              access, err, wr_en, rd_en, clr, hit_end, reload;
  logic [31:0]       wmask, rdata;
  logic              unused_addr_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [31:0] mask);
    return (old & ~mask) | (wdata & mask);
  endfunction

  assign unused_addr_bits = ^apb.paddr_i[31:12];

  // Address decode on word index; unlisted words fall through to SEL_NONE.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    sel      = SEL_NONE;
    duty_idx = '0;
    case (apb.paddr_i[11:2])
      10'd0: sel = SEL_CTRL;
      10'd1: sel = SEL_PERIOD;
      10'd2: sel = SEL_STATUS;
`ifdef PWM_IRQ_EN
      10'd3: sel = SEL_IRQ;
`endif
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (apb.paddr_i[11:2] == 10'(4 + i)) begin
            sel      = SEL_DUTY;
            duty_idx = IDX_W'(i);
          end
        end
      end
    endcase
  end

  assign access = apb.psel_i & apb.penable_i;
  assign err    = access & ((apb.paddr_i[1:0] != 2'b00) | (sel == SEL_NONE) |
                            (apb.pwrite_i & (sel == SEL_STATUS)));
  assign wr_en  = access & apb.pwrite_i & ~err;
  assign rd_en  = access & ~apb.pwrite_i & ~err;
  assign wmask  = {{8{apb.pstrb_i[3]}}, {8{apb.pstrb_i[2]}},
                   {8{apb.pstrb_i[1]}}, {8{apb.pstrb_i[0]}}};

  assign apb.pready_o  = access;
  assign apb.pslverr_o = err;
  assign apb.prdata_o  = rdata;

  always_comb begin
    en_d     = en_q;
    inv_d    = inv_q;
    period_d = period_q;
    duty_d   = duty_q;
    clr      = 1'b0;
    if (wr_en) begin
      case (sel)
        SEL_CTRL: begin
          if (apb.pstrb_i[0]) begin
            en_d  = apb.pwdata_i[0];
            clr   = apb.pwdata_i[1];
            inv_d = apb.pwdata_i[2];
          end
        end
        SEL_PERIOD: period_d = cnt_t'(merge(32'(period_q), apb.pwdata_i, wmask));
        SEL_DUTY:   duty_d[duty_idx] = cnt_t'(merge(32'(duty_q[duty_idx]), apb.pwdata_i, wmask));
        default: ;
      endcase
    end
  end

  // Shadows follow the programmed values (including a write landing this edge) whenever
  // the counter restarts: disabled, cleared, or at the last count of a period.
  assign hit_end = (cnt_q == period_sh_q);
  assign reload  = clr | ~en_q | hit_end;

  always_comb begin
    cnt_d       = reload ? '0 : cnt_q + cnt_t'(1);
    period_sh_d = reload ? period_d : period_sh_q;
    duty_sh_d   = reload ? duty_d : duty_sh_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (en_q & (cnt_q < duty_sh_q[i])) ^ inv_q;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      en_q        <= 1'b0;
      inv_q       <= 1'b0;
      period_q    <= '1;
      period_sh_q <= '1;
      cnt_q       <= '0;
      pwm_q       <= '0;
      // NOTE: the duty arrays are a few flops, not a RAM, so they reset like any other register.
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i]    <= '0;
        duty_sh_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      en_q        <= en_d;
      inv_q       <= inv_d;
      period_q    <= period_d;
      period_sh_q <= period_sh_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      duty_q      <= duty_d;
      duty_sh_q   <= duty_sh_d;
    end
  end

  assign pwm_o = pwm_q;

`ifdef PWM_IRQ_EN
  logic pend_q, pend_d, ie_q, ie_d, irq_q, wrap, w1c;

  // A CLR restart is not a wrap; a wrap in the same cycle as W1C keeps PEND set.
  assign wrap = en_q & hit_end & ~clr;

  always_comb begin
    ie_d = ie_q;
    w1c  = 1'b0;
    if (wr_en && (sel == SEL_IRQ) && apb.pstrb_i[0]) begin
      w1c  = apb.pwdata_i[0];
      ie_d = apb.pwdata_i[1];
    end
    pend_d = wrap | (pend_q & ~w1c);
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      pend_q <= 1'b0;
      ie_q   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ie_q   <= ie_d;
      irq_q  <= pend_q & ie_q;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (sel)
        SEL_CTRL:   rdata = {29'd0, inv_q, 1'b0, en_q};
        SEL_PERIOD: rdata = 32'(period_q);
        SEL_STATUS: rdata = 32'(cnt_q);
`ifdef PWM_IRQ_EN
        SEL_IRQ:    rdata = {30'd0, ie_q, pend_q};
`endif
        SEL_DUTY:   rdata = 32'(duty_q[duty_idx]);
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_pwm_multi.sv
// Self-checking bench for apb_pwm_multi: waveforms are predicted arithmetically from the
// cycle at which the counter was last restarted.
module tb_apb_pwm_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam logic [31:0] CNT_MASK = 32'((64'd1 << CNT_W) - 64'd1);

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic [NUM_CH-1:0] pwm;
  logic              irq;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  apb_pwm_multi_if bus ();

  apb_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .pclk_i   (pclk),
    .preset_i (preset),
    .apb      (bus),
    .pwm_o    (pwm),
    .irq_o    (irq)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Expected outputs n edges after the counter restart edge.
  function automatic logic [NUM_CH-1:0] model_pwm(input int n, input int p, input int d[NUM_CH],
                                                  input bit inv);
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = (((n - 1) % (p + 1)) < d[i]) ^ inv;
    return r;
  endfunction

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic err, output logic rdy, output int w);
    @(posedge pclk); #1;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
    bus.paddr_i = addr; bus.pwdata_i = data; bus.pstrb_i = strb;
    @(posedge pclk); #1;
    bus.penable_i = 1'b1;
    @(negedge pclk);
    err = bus.pslverr_o; rdy = bus.pready_o;
    @(posedge pclk); #1;
    w = cyc;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err,
                          output logic rdy, output int c);
    @(posedge pclk); #1;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = addr;
    @(posedge pclk); #1;
    bus.penable_i = 1'b1;
    @(negedge pclk);
    data = bus.prdata_o; err = bus.pslverr_o; rdy = bus.pready_o; c = cyc;
    @(posedge pclk); #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
  endtask

  // Disable, program period/duties, then enable; e is the edge where counting restarts at 0.
  task automatic configure(input int p, input int d[NUM_CH], input bit inv, output int e);
    logic err, rdy;
    int   w;
    apb_write(32'h0, 32'h0, 4'hF, err, rdy, w);
    apb_write(32'h4, 32'(p), 4'hF, err, rdy, w);
    for (int i = 0; i < NUM_CH; i++) apb_write(32'h10 + 32'(4 * i), 32'(d[i]), 4'hF, err, rdy, w);
    apb_write(32'h0, {29'd0, inv, 2'b01}, 4'hF, err, rdy, e);
  endtask

  task automatic test_reset();
    logic [31:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'h10};
    logic [31:0] exps  [4] = '{32'h0, CNT_MASK, 32'h0, 32'h0};
    logic [31:0] data;
    logic        err, rdy;
    int          c;
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (pwm !== '0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: pwm=%b irq=%b, expected 0 0", pwm, irq);
    end
    n_checks++;
    if (bus.pready_o !== 1'b0 || bus.pslverr_o !== 1'b0 || bus.prdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_idle_bus: pready=%b pslverr=%b prdata=%h, expected 0 0 0",
               bus.pready_o, bus.pslverr_o, bus.prdata_o);
    end
    for (int k = 0; k < 4; k++) begin
      apb_read(addrs[k], data, err, rdy, c);
      n_checks++;
      if (data !== exps[k] || err !== 1'b0 || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read @%h: data=%h err=%b rdy=%b, expected %h 0 1",
                 addrs[k], data, err, rdy, exps[k]);
      end
    end
  endtask

  task automatic test_basic_duty();
    int                d[NUM_CH] = '{3, 0, 10, 5};
    int                e, n, hi;
    logic [NUM_CH-1:0] exp;
    configure(9, d, 1'b0, e);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      n = cyc - e;
      if (n < 1) continue;
      if (n <= 10 && pwm[0] === 1'b1) hi++;
      exp = model_pwm(n, 9, d, 1'b0);
      n_checks++;
      if (pwm !== exp) begin
        n_fail++; $display("FAIL basic_duty n=%0d: pwm=%b, expected %b", n, pwm, exp);
      end
    end
    n_checks++;
    if (hi != 3) begin
      n_fail++; $display("FAIL basic_duty_count: ch0 high %0d of 10 cycles, expected 3", hi);
    end
  endtask

  task automatic test_random_cfg();
    int                d[NUM_CH];
    int                p, e, n, c;
    bit                inv;
    logic [NUM_CH-1:0] exp;
    logic [31:0]       data;
    logic              err, rdy;
    for (int r = 0; r < 5; r++) begin
      p   = (r == 0) ? 0 : $urandom_range(1, 15);
      inv = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_CH; i++) d[i] = $urandom_range(0, p + 2);
      configure(p, d, inv, e);
      for (int k = 0; k < 2 * (p + 1) + 6; k++) begin
        @(negedge pclk);
        n = cyc - e;
        if (n < 1) continue;
        exp = model_pwm(n, p, d, inv);
        n_checks++;
        if (pwm !== exp) begin
          n_fail++; $display("FAIL random_cfg p=%0d n=%0d: pwm=%b, expected %b", p, n, pwm, exp);
        end
      end
      apb_read(32'h8, data, err, rdy, c);
      n_checks++;
      if (data !== 32'((c - e) % (p + 1)) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL random_status p=%0d: cnt=%0d err=%b, expected %0d 0", p, data, err, (c - e) % (p + 1));
      end
    end
  endtask

  task automatic test_midperiod_update();
    int   d[NUM_CH] = '{3, 0, 0, 0};
    int   tgt[3], newv[3];
    int   e, w, m, first, n, j, dd, old;
    logic err, rdy, exp;
    tgt  = '{4, 9, $urandom_range(0, 9)};
    newv = '{7, 2, $urandom_range(0, 11)};
    configure(9, d, 1'b0, e);
    old = 3;
    for (int r = 0; r < 3; r++) begin
      while (((cyc + 1 - e) % 10) != tgt[r]) begin
        @(posedge pclk); #1;
      end
      apb_write(32'h10, 32'(newv[r]), 4'hF, err, rdy, w);
      m     = w - e;
      first = m / 10 + ((m % 10 != 0) ? 1 : 0);
      for (int k = 0; k < 30; k++) begin
        @(negedge pclk);
        n   = cyc - e;
        j   = n - 1;
        dd  = (j / 10 >= first) ? newv[r] : old;
        exp = ((j % 10) < dd);
        n_checks++;
        if (pwm[0] !== exp) begin
          n_fail++;
          $display("FAIL midperiod r=%0d n=%0d: pwm0=%b, expected %b (duty %0d)", r, n, pwm[0], exp, dd);
        end
      end
      old = newv[r];
    end
  endtask

  task automatic test_strobes();
    logic [31:0] p_m, d_m, data, wd, mask;
    logic [3:0]  strb;
    logic        err, rdy;
    int          w, c;
    apb_write(32'h0, 32'h0, 4'hF, err, rdy, w);
    apb_write(32'h4, 32'h0000_1234, 4'hF, err, rdy, w);
    apb_write(32'h14, 32'h0000_0000, 4'hF, err, rdy, w);
    p_m = 32'h1234;
    d_m = 32'h0;
    for (int r = 0; r < 4; r++) begin
      wd   = $urandom;
      strb = (r == 0) ? 4'b0001 : 4'($urandom_range(0, 15));
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
      p_m = ((p_m & ~mask) | (wd & mask)) & CNT_MASK;
      apb_write(32'h4, wd, strb, err, rdy, w);
      apb_read(32'h4, data, err, rdy, c);
      n_checks++;
      if (data !== p_m) begin
        n_fail++; $display("FAIL strobe_period strb=%b: got %h, expected %h", strb, data, p_m);
      end
      wd   = $urandom;
      d_m  = ((d_m & ~mask) | (wd & mask)) & CNT_MASK;
      apb_write(32'h14, wd, strb, err, rdy, w);
      apb_read(32'h14, data, err, rdy, c);
      n_checks++;
      if (data !== d_m) begin
        n_fail++; $display("FAIL strobe_duty1 strb=%b: got %h, expected %h", strb, data, d_m);
      end
    end
    apb_write(32'h0, 32'h7, 4'h0, err, rdy, w);
    apb_read(32'h0, data, err, rdy, c);
    n_checks++;
    if (data !== 32'h0) begin
      n_fail++; $display("FAIL strobe_ctrl_none: got %h, expected 0", data);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    bit          exp_err;
  } err_case_t;

  task automatic test_errors();
    err_case_t   cases[8];
    logic [31:0] data;
    logic        err, rdy;
    int          w, c;
`ifdef PWM_IRQ_EN
    bit irq_err = 1'b0;
`else
    bit irq_err = 1'b1;
`endif
    cases = '{'{32'h02, 1'b0, 1'b1}, '{32'h40, 1'b0, 1'b1}, '{32'h08, 1'b1, 1'b1},
              '{32'h05, 1'b1, 1'b1}, '{32'h0C, 1'b0, irq_err}, '{32'h20, 1'b0, 1'b1},
              '{32'h1C, 1'b0, 1'b0}, '{32'h1004, 1'b0, 1'b0}};
    apb_write(32'h4, 32'h0000_0055, 4'hF, err, rdy, w);
    for (int k = 0; k < 8; k++) begin
      if (cases[k].wr) apb_write(cases[k].addr, 32'hFFFF_FFFF, 4'hF, err, rdy, w);
      else apb_read(cases[k].addr, data, err, rdy, c);
      n_checks++;
      if (err !== cases[k].exp_err || rdy !== 1'b1 ||
          (!cases[k].wr && cases[k].exp_err && data !== 32'h0)) begin
        n_fail++;
        $display("FAIL err_case @%h wr=%0d: pslverr=%b pready=%b, expected %b 1", cases[k].addr,
                 cases[k].wr, err, rdy, cases[k].exp_err);
      end
    end
    apb_read(32'h4, data, err, rdy, c);
    n_checks++;
    if (data !== 32'h55 || err !== 1'b0) begin
      n_fail++; $display("FAIL err_period_unchanged: got %h err=%b, expected 00000055 0", data, err);
    end
    apb_read(32'h0, data, err, rdy, c);
    n_checks++;
    if (data !== 32'h0) begin
      n_fail++; $display("FAIL err_ctrl_unchanged: got %h, expected 0", data);
    end
  endtask

  task automatic test_clr_inv();
    int                d[NUM_CH] = '{3, 6, 0, 11};
    int                e, w, c, n, lo;
    logic [NUM_CH-1:0] exp;
    logic [31:0]       data;
    logic              err, rdy;
    configure(9, d, 1'b0, e);
    while (((cyc + 1 - e) % 10) != 5) begin
      @(posedge pclk); #1;
    end
    apb_write(32'h0, 32'h3, 4'hF, err, rdy, w);
    e = w;
    apb_read(32'h8, data, err, rdy, c);
    n_checks++;
    if (data !== 32'((c - e) % 10)) begin
      n_fail++; $display("FAIL clr_status: cnt=%0d, expected %0d", data, (c - e) % 10);
    end
    apb_read(32'h0, data, err, rdy, c);
    n_checks++;
    if (data !== 32'h1) begin
      n_fail++; $display("FAIL clr_readback: ctrl=%h, expected 00000001", data);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      n   = cyc - e;
      exp = model_pwm(n, 9, d, 1'b0);
      n_checks++;
      if (pwm !== exp) begin
        n_fail++; $display("FAIL clr_wave n=%0d: pwm=%b, expected %b", n, pwm, exp);
      end
    end
    apb_write(32'h0, 32'h7, 4'hF, err, rdy, e);
    lo = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge pclk);
      n = cyc - e;
      if (n < 1) continue;
      if (n <= 10 && pwm[0] === 1'b0) lo++;
      exp = model_pwm(n, 9, d, 1'b1);
      n_checks++;
      if (pwm !== exp) begin
        n_fail++; $display("FAIL inv_wave n=%0d: pwm=%b, expected %b", n, pwm, exp);
      end
    end
    n_checks++;
    if (lo != 3) begin
      n_fail++; $display("FAIL inv_count: ch0 low %0d of 10 cycles, expected 3", lo);
    end
    apb_write(32'h0, 32'h0, 4'hF, err, rdy, w);
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      if (cyc < w + 1) continue;
      n_checks++;
      if (pwm !== '0) begin
        n_fail++; $display("FAIL disable_wave t=%0d: pwm=%b, expected 0", cyc - w, pwm);
      end
    end
    apb_read(32'h8, data, err, rdy, c);
    n_checks++;
    if (data !== 32'h0) begin
      n_fail++; $display("FAIL disable_status: cnt=%0d, expected 0", data);
    end
  endtask

  task automatic test_irq();
    int   d[NUM_CH] = '{2, 0, 0, 0};
    int   e, w, t;
    logic err, rdy, exp;
`ifdef PWM_IRQ_EN
    logic [31:0] data;
    int          c;
    apb_write(32'h0, 32'h0, 4'hF, err, rdy, w);
    apb_write(32'hC, 32'h3, 4'hF, err, rdy, w);
    apb_write(32'h4, 32'h4, 4'hF, err, rdy, w);
    apb_write(32'h10, 32'(d[0]), 4'hF, err, rdy, w);
    apb_write(32'h0, 32'h1, 4'hF, err, rdy, e);
    for (int k = 0; k < 13; k++) begin
      @(negedge pclk);
      t = cyc - e;
      if (t < 1) continue;
      exp = (t >= 6);
      n_checks++;
      if (irq !== exp) begin
        n_fail++; $display("FAIL irq_first_wrap n=%0d: irq=%b, expected %b", t, irq, exp);
      end
    end
    while (((cyc + 2 - e) % 5) != 2) begin
      @(posedge pclk); #1;
    end
    apb_write(32'hC, 32'h3, 4'hF, err, rdy, w);
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      t = cyc - w;
      if (t < 1) continue;
      exp = (t >= 4);
      n_checks++;
      if (irq !== exp) begin
        n_fail++; $display("FAIL irq_w1c t=%0d: irq=%b, expected %b", t, irq, exp);
      end
    end
    while (((cyc + 2 - e) % 5) != 0) begin
      @(posedge pclk); #1;
    end
    apb_write(32'hC, 32'h3, 4'hF, err, rdy, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      t = cyc - w;
      if (t < 1) continue;
      n_checks++;
      if (irq !== 1'b1) begin
        n_fail++; $display("FAIL irq_w1c_on_wrap t=%0d: irq=%b, expected 1", t, irq);
      end
    end
    apb_read(32'hC, data, err, rdy, c);
    n_checks++;
    if (data !== 32'h3 || err !== 1'b0) begin
      n_fail++; $display("FAIL irq_readback: got %h err=%b, expected 00000003 0", data, err);
    end
    apb_write(32'hC, 32'h0, 4'hF, err, rdy, w);
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      if (cyc < w + 1) continue;
      n_checks++;
      if (irq !== 1'b0) begin
        n_fail++; $display("FAIL irq_ie_off t=%0d: irq=%b, expected 0", cyc - w, irq);
      end
    end
`else
    configure(4, d, 1'b0, e);
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      n_checks++;
      if (irq !== 1'b0) begin
        n_fail++; $display("FAIL irq_tied_low n=%0d: irq=%b, expected 0", cyc - e, irq);
      end
    end
    apb_write(32'hC, 32'h3, 4'hF, err, rdy, w);
    exp = 1'b1;
    n_checks++;
    if (err !== exp) begin
      n_fail++; $display("FAIL irq_reg_absent: pslverr=%b, expected 1", err);
    end
`endif
  endtask

  task automatic test_reset_midop();
    int          d[NUM_CH] = '{3, 6, 0, 11};
    logic [31:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'h14};
    logic [31:0] exps  [4] = '{32'h0, CNT_MASK, 32'h0, 32'h0};
    logic [31:0] data;
    logic        err, rdy;
    int          e, c;
    configure(9, d, 1'b1, e);
    repeat (13) @(posedge pclk);
    #1 preset = 1'b1;
    @(posedge pclk);
    #1 preset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      n_checks++;
      if (pwm !== '0 || irq !== 1'b0) begin
        n_fail++; $display("FAIL midop_reset_out k=%0d: pwm=%b irq=%b, expected 0 0", k, pwm, irq);
      end
    end
    for (int k = 0; k < 4; k++) begin
      apb_read(addrs[k], data, err, rdy, c);
      n_checks++;
      if (data !== exps[k] || err !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_reset_read @%h: data=%h err=%b, expected %h 0", addrs[k], data, err, exps[k]);
      end
    end
  endtask

  initial begin
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    bus.paddr_i   = 32'h0;
    bus.pwdata_i  = 32'h0;
    bus.pstrb_i   = 4'h0;
    test_reset();
    test_basic_duty();
    test_random_cfg();
    test_midperiod_update();
    test_strobes();
    test_errors();
    test_clr_inv();
    test_irq();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
